// File: rtl/player_ctrl.sv
// player_ctrl: per-player motion controller for the soccer game.
// One instance per player, advanced once per video frame. Decodes two USB
// keycode slots, then produces the sprite position, signed velocities, facing,
// walk animation frame and a kick window. Every output comes straight from a flop.
module player_ctrl #(
    parameter int         X_MIN         = 0,
    parameter int         X_MAX         = 639,
    parameter int         Y_MIN         = 0,
    parameter int         Y_MAX         = 460,
    parameter int         SIZE_X        = 24,
    parameter int         SIZE_Y        = 32,
    parameter int         START_X       = 64,
    parameter int         EDGE_MARGIN   = 5,
    parameter int         WALK_SPEED    = 2,
    parameter int         ACCEL_PERIOD  = 4,
    parameter int         JUMP_VEL      = 5,
    parameter int         GRAV_PERIOD   = 10,
    parameter int         MAX_FALL      = 6,
    parameter int         ANIM_FRAMES   = 2,
    parameter int         ANIM_PERIOD   = 15,
    parameter logic [7:0] KEY_LEFT      = 8'h04,
    parameter logic [7:0] KEY_RIGHT     = 8'h07,
    parameter logic [7:0] KEY_JUMP      = 8'h1A,
    parameter logic [7:0] KEY_KICK      = 8'h2C,
    parameter int         KICK_FRAMES   = 8,
    parameter int         KICK_COOLDOWN = 12
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic                     AllowInput,
    input  logic [7:0]               keycode,
    input  logic [7:0]               keycode2,
    output logic [9:0]               PlayerX,
    output logic [9:0]               PlayerY,
    output logic [9:0]               PlayerSX,
    output logic [9:0]               PlayerSY,
    output logic signed [9:0]        XMotion,
    output logic signed [9:0]        YMotion,
    output logic                     facing,
    output logic [((ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1)-1:0] anim_frame,
    output logic                     on_ground,
    output logic                     kicking
);

    localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    // Playfield bounds for the sprite centre, widened so signed compares never wrap.
    localparam logic signed [11:0] X_LO  = 12'(X_MIN + EDGE_MARGIN + SIZE_X);
    localparam logic signed [11:0] X_HI  = 12'(X_MAX - EDGE_MARGIN - SIZE_X);
    localparam logic signed [11:0] Y_GND = 12'(Y_MAX - SIZE_Y);
    localparam logic signed [11:0] Y_TOP = 12'(Y_MIN + SIZE_Y);

    localparam logic signed [9:0] WALK_V = 10'(WALK_SPEED);
    localparam logic signed [9:0] JUMP_V = 10'(JUMP_VEL);
    localparam logic signed [9:0] FALL_V = 10'(MAX_FALL);

    // Terminal counts; a period of 0 or 1 means "every frame".
    localparam logic [15:0] ACC_LAST  = (ACCEL_PERIOD  > 1) ? 16'(ACCEL_PERIOD  - 1) : 16'd0;
    localparam logic [15:0] GRAV_LAST = (GRAV_PERIOD   > 1) ? 16'(GRAV_PERIOD   - 1) : 16'd0;
    localparam logic [15:0] ANIM_LAST = (ANIM_PERIOD   > 1) ? 16'(ANIM_PERIOD   - 1) : 16'd0;
    localparam logic [15:0] KICK_LAST = (KICK_FRAMES   > 1) ? 16'(KICK_FRAMES   - 1) : 16'd0;
    localparam logic [15:0] COOL_LAST = (KICK_COOLDOWN > 1) ? 16'(KICK_COOLDOWN - 1) : 16'd0;
    localparam logic [AW-1:0] FRAME_LAST = (ANIM_FRAMES > 1) ? AW'(ANIM_FRAMES - 1) : '0;

    // Refuse to build with bounds or speeds that do not fit the 10-bit datapath.
    if (X_MAX > 1023 || Y_MAX > 1023 || X_MIN < 0 || Y_MIN < 0 ||
        START_X > 1023 || SIZE_X > 1023 || SIZE_Y > 1023 ||
        (X_MIN + EDGE_MARGIN + SIZE_X) > (X_MAX - EDGE_MARGIN - SIZE_X) ||
        (Y_MIN + SIZE_Y) > (Y_MAX - SIZE_Y) ||
        WALK_SPEED > 511 || JUMP_VEL > 511 || MAX_FALL > 511) begin : g_bad_params
        $error("player_ctrl: parameters do not fit in 10 bits");
    end

    typedef enum logic {V_GROUND, V_AIR} v_state_e;
    typedef enum logic [1:0] {K_IDLE, K_KICK, K_COOL} k_state_e;

    logic               press_l, press_r, press_j, press_k;
    logic signed [9:0]  target;
    logic signed [11:0] next_x, next_y;

    logic [9:0]         player_x_q, player_x_d;
    logic [9:0]         player_y_q, player_y_d;
    logic signed [9:0]  x_motion_q, x_motion_d;
    logic signed [9:0]  y_motion_q, y_motion_d;
    logic               facing_q, facing_d;
    logic [15:0]        acc_cnt_q, acc_cnt_d;
    logic [15:0]        grav_cnt_q, grav_cnt_d;
    logic [15:0]        anim_cnt_q, anim_cnt_d;
    logic [AW-1:0]      anim_frame_q, anim_frame_d;
    v_state_e           v_state_q, v_state_d;
    logic               on_ground_q, on_ground_d;
    k_state_e           k_state_q, k_state_d;
    logic [15:0]        kick_cnt_q, kick_cnt_d;
    logic               kicking_q, kicking_d;
    logic               kick_prev_q, kick_prev_d;

    // Key decode: either slot may carry a binding; gating forces everything released.
    always_comb begin
        press_l = AllowInput && (keycode == KEY_LEFT  || keycode2 == KEY_LEFT);
        press_r = AllowInput && (keycode == KEY_RIGHT || keycode2 == KEY_RIGHT);
        press_j = AllowInput && (keycode == KEY_JUMP  || keycode2 == KEY_JUMP);
        press_k = AllowInput && (keycode == KEY_KICK  || keycode2 == KEY_KICK);
    end

    // Horizontal: ramp velocity toward the key target, move by the old velocity, clamp at walls.
    always_comb begin
        target   = '0;
        facing_d = facing_q;
        if (press_r && !press_l) begin
            target   = WALK_V;
            facing_d = 1'b1;
        end else if (press_l && !press_r) begin
            target   = -WALK_V;
            facing_d = 1'b0;
        end

        x_motion_d = x_motion_q;
        acc_cnt_d  = '0;
        if (x_motion_q != target) begin
            if (ACCEL_PERIOD == 0) begin
                x_motion_d = target;
            end else if (acc_cnt_q == ACC_LAST) begin
                x_motion_d = (x_motion_q < target) ? x_motion_q + 10'sd1 : x_motion_q - 10'sd1;
            end else begin
                acc_cnt_d = acc_cnt_q + 16'd1;
            end
        end

        next_x     = $signed({2'b00, player_x_q}) + $signed({{2{x_motion_q[9]}}, x_motion_q});
        player_x_d = next_x[9:0];
        if (next_x < X_LO) begin
            player_x_d = X_LO[9:0];
            x_motion_d = '0;
            acc_cnt_d  = '0;
        end else if (next_x > X_HI) begin
            player_x_d = X_HI[9:0];
            x_motion_d = '0;
            acc_cnt_d  = '0;
        end
    end

    // Vertical: ground/air state with periodic gravity, landing snap and ceiling stop.
    always_comb begin
        v_state_d   = v_state_q;
        player_y_d  = player_y_q;
        y_motion_d  = y_motion_q;
        grav_cnt_d  = grav_cnt_q;
        on_ground_d = on_ground_q;
        next_y      = $signed({2'b00, player_y_q}) + $signed({{2{y_motion_q[9]}}, y_motion_q});
        case (v_state_q)
            V_GROUND: begin
                y_motion_d  = '0;
                on_ground_d = 1'b1;
                if (press_j) begin
                    y_motion_d  = -JUMP_V;
                    v_state_d   = V_AIR;
                    on_ground_d = 1'b0;
                    grav_cnt_d  = '0;
                end
            end
            default: begin
                if (grav_cnt_q == GRAV_LAST) begin
                    grav_cnt_d = '0;
                    y_motion_d = (y_motion_q >= FALL_V) ? FALL_V : y_motion_q + 10'sd1;
                end else begin
                    grav_cnt_d = grav_cnt_q + 16'd1;
                end
                if (!y_motion_q[9] && next_y >= Y_GND) begin
                    player_y_d  = Y_GND[9:0];
                    y_motion_d  = '0;
                    v_state_d   = V_GROUND;
                    on_ground_d = 1'b1;
                end else if (next_y < Y_TOP) begin
                    player_y_d = Y_TOP[9:0];
                    y_motion_d = '0;
                end else begin
                    player_y_d = next_y[9:0];
                end
            end
        endcase
    end

    // Walk animation: runs only while the new velocity is non-zero, otherwise parks on frame 0.
    always_comb begin
        anim_frame_d = anim_frame_q;
        anim_cnt_d   = anim_cnt_q;
        if (x_motion_d == '0) begin
            anim_frame_d = '0;
            anim_cnt_d   = '0;
        end else if (anim_cnt_q == ANIM_LAST) begin
            anim_cnt_d   = '0;
            anim_frame_d = (anim_frame_q == FRAME_LAST) ? '0 : anim_frame_q + AW'(1);
        end else begin
            anim_cnt_d = anim_cnt_q + 16'd1;
        end
    end

    // Kick: fire on a fresh press, hold the window, then cool down before re-arming.
    always_comb begin
        k_state_d   = k_state_q;
        kick_cnt_d  = kick_cnt_q;
        kicking_d   = kicking_q;
        kick_prev_d = press_k;
        case (k_state_q)
            K_IDLE: begin
                kicking_d = 1'b0;
                if (press_k && !kick_prev_q) begin
                    k_state_d  = K_KICK;
                    kick_cnt_d = '0;
                    kicking_d  = 1'b1;
                end
            end
            K_KICK: begin
                if (kick_cnt_q == KICK_LAST) begin
                    k_state_d  = K_COOL;
                    kick_cnt_d = '0;
                    kicking_d  = 1'b0;
                end else begin
                    kick_cnt_d = kick_cnt_q + 16'd1;
                end
            end
            default: begin
                kicking_d = 1'b0;
                if (kick_cnt_q == COOL_LAST) begin
                    k_state_d  = K_IDLE;
                    kick_cnt_d = '0;
                end else begin
                    kick_cnt_d = kick_cnt_q + 16'd1;
                end
            end
        endcase
    end

    // State register for the whole controller; reset drops any jump or kick in progress.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            player_x_q   <= 10'(START_X);
            player_y_q   <= Y_GND[9:0];
            x_motion_q   <= '0;
            y_motion_q   <= '0;
            facing_q     <= 1'b1;
            acc_cnt_q    <= '0;
            grav_cnt_q   <= '0;
            anim_cnt_q   <= '0;
            anim_frame_q <= '0;
            v_state_q    <= V_GROUND;
            on_ground_q  <= 1'b1;
            k_state_q    <= K_IDLE;
            kick_cnt_q   <= '0;
            kicking_q    <= 1'b0;
            kick_prev_q  <= 1'b0;
        end else begin
            player_x_q   <= player_x_d;
            player_y_q   <= player_y_d;
            x_motion_q   <= x_motion_d;
            y_motion_q   <= y_motion_d;
            facing_q     <= facing_d;
            acc_cnt_q    <= acc_cnt_d;
            grav_cnt_q   <= grav_cnt_d;
            anim_cnt_q   <= anim_cnt_d;
            anim_frame_q <= anim_frame_d;
            v_state_q    <= v_state_d;
            on_ground_q  <= on_ground_d;
            k_state_q    <= k_state_d;
            kick_cnt_q   <= kick_cnt_d;
            kicking_q    <= kicking_d;
            kick_prev_q  <= kick_prev_d;
        end
    end

    assign PlayerX    = player_x_q;
    assign PlayerY    = player_y_q;
    assign PlayerSX   = 10'(SIZE_X);
    assign PlayerSY   = 10'(SIZE_Y);
    assign XMotion    = x_motion_q;
    assign YMotion    = y_motion_q;
    assign facing     = facing_q;
    assign anim_frame = anim_frame_q;
    assign on_ground  = on_ground_q;
    assign kicking    = kicking_q;

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed stimulus for player_ctrl with default parameters,
// a frame-level reference model compared every frame, and hand-computed pins.
module tb_player_ctrl;

    logic              frame_clk = 1'b0;
    logic              Reset = 1'b1;
    logic              AllowInput = 1'b1;
    logic [7:0]        keycode = 8'h00;
    logic [7:0]        keycode2 = 8'h00;
    logic [9:0]        PlayerX, PlayerY, PlayerSX, PlayerSY;
    logic signed [9:0] XMotion, YMotion;
    logic              facing;
    logic [0:0]        anim_frame;
    logic              on_ground;
    logic              kicking;

    int errors = 0;
    int checks = 0;

    always #5 frame_clk = ~frame_clk;

    player_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .AllowInput(AllowInput),
        .keycode   (keycode),
        .keycode2  (keycode2),
        .PlayerX   (PlayerX),
        .PlayerY   (PlayerY),
        .PlayerSX  (PlayerSX),
        .PlayerSY  (PlayerSY),
        .XMotion   (XMotion),
        .YMotion   (YMotion),
        .facing    (facing),
        .anim_frame(anim_frame),
        .on_ground (on_ground),
        .kicking   (kicking)
    );

    // Reference model state (plain integers, one update per frame).
    int m_x = 64, m_y = 428, m_xm = 0, m_ym = 0;
    int m_acc = 0, m_grav = 0, m_anim = 0, m_anim_cnt = 0;
    int m_n = 0, m_trig = -1, m_ready = 0;
    bit m_facing = 1'b1, m_air = 1'b0, m_kprev = 1'b0, m_kicking = 1'b0;

    task automatic model_reset();
        m_x = 64; m_y = 428; m_xm = 0; m_ym = 0;
        m_acc = 0; m_grav = 0; m_anim = 0; m_anim_cnt = 0;
        m_n = 0; m_trig = -1; m_ready = 0;
        m_facing = 1'b1; m_air = 1'b0; m_kprev = 1'b0; m_kicking = 1'b0;
    endtask

    task automatic model_step();
        bit pl, pr, pj, pk;
        int tgt, nx, ny, vy_next;
        pl = AllowInput && (keycode == 8'h04 || keycode2 == 8'h04);
        pr = AllowInput && (keycode == 8'h07 || keycode2 == 8'h07);
        pj = AllowInput && (keycode == 8'h1A || keycode2 == 8'h1A);
        pk = AllowInput && (keycode == 8'h2C || keycode2 == 8'h2C);

        tgt = (pr && !pl) ? 2 : ((pl && !pr) ? -2 : 0);
        if (pr && !pl) m_facing = 1'b1;
        else if (pl && !pr) m_facing = 1'b0;
        nx = m_x + m_xm;
        if (m_xm == tgt) m_acc = 0;
        else if (m_acc == 3) begin m_xm = m_xm + ((tgt > m_xm) ? 1 : -1); m_acc = 0; end
        else m_acc = m_acc + 1;
        if (nx < 29) begin m_x = 29; m_xm = 0; m_acc = 0; end
        else if (nx > 610) begin m_x = 610; m_xm = 0; m_acc = 0; end
        else m_x = nx;

        if (m_xm == 0) begin m_anim = 0; m_anim_cnt = 0; end
        else if (m_anim_cnt == 14) begin m_anim = (m_anim + 1) % 2; m_anim_cnt = 0; end
        else m_anim_cnt = m_anim_cnt + 1;

        if (!m_air) begin
            m_ym = 0;
            if (pj) begin m_ym = -5; m_air = 1'b1; m_grav = 0; end
        end else begin
            ny = m_y + m_ym;
            vy_next = m_ym;
            if (m_grav == 9) begin vy_next = (m_ym + 1 > 6) ? 6 : m_ym + 1; m_grav = 0; end
            else m_grav = m_grav + 1;
            if (m_ym >= 0 && ny >= 428) begin m_y = 428; m_ym = 0; m_air = 1'b0; end
            else if (ny < 32) begin m_y = 32; m_ym = 0; end
            else begin m_y = ny; m_ym = vy_next; end
        end

        // A kick may start only on a fresh press at least KICK+COOLDOWN+1 frames after the last start.
        if (pk && !m_kprev && m_n >= m_ready) begin
            m_trig  = m_n;
            m_ready = m_n + 8 + 12 + 1;
        end
        m_kicking = (m_trig >= 0) && (m_n - m_trig < 8);
        m_kprev   = pk;
        m_n       = m_n + 1;
    endtask

    initial begin
        forever begin
            @(posedge frame_clk or posedge Reset);
            if (Reset) model_reset();
            else model_step();
        end
    end

    // Per-frame comparison of every output against the model.
    initial begin
        forever begin
            @(negedge frame_clk);
            if (!Reset) begin
                checks++;
                if (PlayerX !== 10'(m_x) || PlayerY !== 10'(m_y) ||
                    XMotion !== 10'(m_xm) || YMotion !== 10'(m_ym) ||
                    facing !== m_facing || anim_frame !== 1'(m_anim) ||
                    on_ground !== !m_air || kicking !== m_kicking ||
                    PlayerSX !== 10'd24 || PlayerSY !== 10'd32) begin
                    errors++;
                    $display("FAIL model t=%0t X=%0d/%0d Y=%0d/%0d XM=%0d/%0d YM=%0d/%0d face=%0b/%0b anim=%0d/%0d gnd=%0b/%0b kick=%0b/%0b SX=%0d SY=%0d (dut/required)",
                             $time, PlayerX, m_x, PlayerY, m_y, XMotion, m_xm, YMotion, m_ym,
                             facing, m_facing, anim_frame, m_anim, on_ground, !m_air,
                             kicking, m_kicking, PlayerSX, PlayerSY);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        int  land_ticks, min_y, clamp_ticks, min_x, kick_ones;
        bit  done;

        tick(2);
        chk("rst_x", PlayerX, 64);
        chk("rst_y", PlayerY, 428);
        chk("rst_xm", XMotion, 0);
        chk("rst_ym", YMotion, 0);
        chk("rst_gnd", on_ground, 1);
        chk("rst_face", facing, 1);
        chk("rst_kick", kicking, 0);
        chk("rst_anim", anim_frame, 0);
        Reset = 1'b0;

        // Walk right: velocity ramps one unit per 4 frames, position lags by a frame.
        keycode = 8'h07;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 3) chk("acc_e3_xm", XMotion, 0);
            if (e == 4) begin chk("acc_e4_xm", XMotion, 1); chk("acc_e4_x", PlayerX, 64); end
            if (e == 8) begin chk("acc_e8_xm", XMotion, 2); chk("acc_e8_x", PlayerX, 68); end
            if (e == 17) chk("anim_e17", anim_frame, 0);
            if (e == 18) chk("anim_e18", anim_frame, 1);
            if (e == 33) begin chk("anim_e33", anim_frame, 0); chk("walk_e33_x", PlayerX, 118); end
        end

        // Input gated off with the key still held: decelerate to rest.
        AllowInput = 1'b0;
        tick(4);
        chk("gate_xm4", XMotion, 1);
        tick(4);
        chk("gate_xm8", XMotion, 0);
        chk("gate_anim", anim_frame, 0);
        chk("gate_x", PlayerX, 130);

        // Single-frame jump press on the second slot.
        AllowInput = 1'b1;
        keycode    = 8'h00;
        keycode2   = 8'h1A;
        tick();
        chk("jump_ym", YMotion, -5);
        chk("jump_ym_raw", int'(YMotion[9:0]), 'h3FB);
        chk("jump_gnd", on_ground, 0);
        chk("jump_y0", PlayerY, 428);
        keycode2 = 8'h00;
        tick();
        chk("jump_y1", PlayerY, 423);
        done = 1'b0; land_ticks = 0; min_y = 1023;
        while (!done && land_ticks < 400) begin
            tick();
            land_ticks++;
            if (PlayerY < min_y) min_y = PlayerY;
            if (on_ground) done = 1'b1;
        end
        chk("land_ticks", land_ticks, 109);
        chk("ceiling_ok", (min_y >= 32) ? 1 : 0, 1);
        chk("land_y", PlayerY, 428);
        chk("land_ym", YMotion, 0);
        chk("land_gnd", on_ground, 1);

        // Walk left into the wall.
        keycode = 8'h04;
        done = 1'b0; clamp_ticks = 0;
        while (!done && clamp_ticks < 200) begin
            tick();
            clamp_ticks++;
            if (PlayerX == 29) done = 1'b1;
        end
        chk("clamp_ticks", clamp_ticks, 57);
        chk("clamp_x", PlayerX, 29);
        chk("clamp_xm", XMotion, 0);
        chk("clamp_face", facing, 0);
        min_x = 1023;
        repeat (20) begin
            tick();
            if (PlayerX < min_x) min_x = PlayerX;
        end
        chk("clamp_hold_min_x", min_x, 29);

        // Kick held for 40 frames: one 8-frame window, no retrigger.
        keycode = 8'h2C;
        tick();
        chk("kick1_start", kicking, 1);
        kick_ones = kicking;
        repeat (39) begin
            tick();
            kick_ones += kicking;
        end
        chk("kick1_len", kick_ones, 8);
        chk("kick1_no_retrigger", kicking, 0);
        keycode = 8'h00;
        tick();
        keycode = 8'h2C;
        tick();
        chk("kick2_start", kicking, 1);
        AllowInput = 1'b0;
        tick(3);
        chk("kick2_gate_holds", kicking, 1);
        AllowInput = 1'b1;
        keycode    = 8'h00;
        tick(16);
        keycode = 8'h2C;
        tick();
        chk("kick_in_cooldown", kicking, 0);
        keycode = 8'h00;
        tick();
        keycode = 8'h2C;
        tick();
        chk("kick3_start", kicking, 1);
        tick(2);

        // Asynchronous reset in the middle of a kick.
        #2 Reset = 1'b1;
        #1;
        chk("rst_async_kick", kicking, 0);
        chk("rst_async_x", PlayerX, 64);
        chk("rst_async_gnd", on_ground, 1);
        @(negedge frame_clk);
        Reset   = 1'b0;
        keycode = 8'h00;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
